// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter between instruction fetch and data access.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    // Wide enough to hold the longest strobe phase without wrapping.
    function automatic int unsigned cnt_width(input int unsigned read_cycles,
                                              input int unsigned we_cycles);
        int unsigned longest;
        longest = (read_cycles > we_cycles) ? read_cycles : we_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester ports (IF and MEM) plus SRAM control pins of the arbiter, bundled with modports.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic [DATA_W-1:0]     if_rdata_o;
    logic                  if_ack_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [DATA_W/8-1:0]   mem_be_i;
    logic [ADDR_W-1:0]     mem_addr_i;
    logic [DATA_W-1:0]     mem_wdata_i;
    logic [DATA_W-1:0]     mem_rdata_o;
    logic                  mem_ack_o;

    logic                  stall_if_o;

    logic [ADDR_W-1:0]     sram_addr_o;
    logic                  sram_ce_n_o;
    logic                  sram_oe_n_o;
    logic                  sram_we_n_o;
    logic [DATA_W/8-1:0]   sram_be_n_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
        output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_if_o,
        output sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
        input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_if_o,
        input  sram_addr_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
    );

endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates IF and MEM onto one asynchronous SRAM, sequencing CE/OE/WE/BE with a multi-cycle FSM.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned READ_CYCLES = 1,
    parameter int unsigned WE_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    inout  wire [DATA_W-1:0]  sram_data_io
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = cnt_width(READ_CYCLES, WE_CYCLES);
    localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LOAD   = CNT_W'(WE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               grant_q, grant_d;
    logic               we_q, we_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic               if_ack_q, if_ack_d;
    logic               mem_ack_q, mem_ack_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic [BE_W-1:0]    be_n_q, be_n_d;
    logic               bus_oe_q, bus_oe_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req_i || bus.mem_req_i) begin
                    // On contention MEM wins unless it won last time.
                    if (bus.if_req_i && bus.mem_req_i) begin
                        grant_d = (last_q == GRANT_MEM) ? GRANT_IF : GRANT_MEM;
                    end else begin
                        grant_d = bus.mem_req_i ? GRANT_MEM : GRANT_IF;
                    end
                    last_d = grant_d;
                    if (grant_d == GRANT_MEM) begin
                        addr_d  = bus.mem_addr_i;
                        we_d    = bus.mem_we_i;
                        be_d    = bus.mem_be_i;
                        wdata_d = bus.mem_wdata_i;
                    end else begin
                        addr_d = bus.if_addr_i;
                        we_d   = 1'b0;
                        be_d   = '1;
                    end
                    if (!we_d) begin
                        state_d = StRead;
                    end else if (be_d == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWrSetup;
                    end
                end
            end
            StRead: begin
                if (cnt_q == '0) begin
                    if (grant_q == GRANT_IF) begin
                        if_rdata_d = sram_data_io;
                    end else begin
                        mem_rdata_d = sram_data_io;
                    end
                    state_d = StDone;
                end
            end
            StWrSetup: state_d = StWrPulse;
            StWrPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWrHold;
                end
            end
            StWrHold:  state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = (state_d == StRead)    ? READ_LOAD :
                    (state_d == StWrPulse) ? WE_LOAD   : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Pin values are decoded from the next state so they change exactly on state entry.
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        be_n_d   = '1;
        bus_oe_d = 1'b0;
        unique case (state_d)
            StRead: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            StWrSetup, StWrHold: begin
                ce_n_d   = 1'b0;
                be_n_d   = ~be_d;
                bus_oe_d = 1'b1;
            end
            StWrPulse: begin
                ce_n_d   = 1'b0;
                we_n_d   = 1'b0;
                be_n_d   = ~be_d;
                bus_oe_d = 1'b1;
            end
            default: ;
        endcase

        if_ack_d  = (state_d == StDone) && (grant_d == GRANT_IF);
        mem_ack_d = (state_d == StDone) && (grant_d == GRANT_MEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= GRANT_IF;
            grant_q     <= GRANT_IF;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= '1;
            bus_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            bus_oe_q    <= bus_oe_d;
        end
    end

    assign sram_data_io    = bus_oe_q ? wdata_q : 'z;
    assign bus.sram_addr_o = addr_q;
    assign bus.sram_ce_n_o = ce_n_q;
    assign bus.sram_oe_n_o = oe_n_q;
    assign bus.sram_we_n_o = we_n_q;
    assign bus.sram_be_n_o = be_n_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.mem_ack_o   = mem_ack_q;
    assign bus.stall_if_o  = bus.if_req_i & ~if_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default timing instance plus a READ_CYCLES=3/WE_CYCLES=1 instance.
module tb_sram_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    wire [31:0] d0;
    wire [31:0] d1;
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    sram_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus0 ();
    sram_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus1 ();

    sram_arbiter #(.ADDR_W(20), .DATA_W(32), .READ_CYCLES(1), .WE_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0),
        .sram_data_io (d0)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(32), .READ_CYCLES(3), .WE_CYCLES(1)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus1),
        .sram_data_io (d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM models: drive on CE&OE&~WE, capture enabled bytes while CE&WE are low.
    assign d0 = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o && bus0.sram_we_n_o)
                ? mem0[bus0.sram_addr_o[9:0]] : 'z;
    assign d1 = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o && bus1.sram_we_n_o)
                ? mem1[bus1.sram_addr_o[9:0]] : 'z;

    always @(negedge clk) begin
        if (rst) begin
            mem0[10'h010] <= 32'h8C220004;
            mem0[10'h100] <= 32'h12345678;
            mem0[10'h200] <= 32'hCAFEF00D;
            mem0[10'h300] <= 32'h55AA55AA;
        end else if (!bus0.sram_ce_n_o && !bus0.sram_we_n_o) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus0.sram_be_n_o[b]) mem0[bus0.sram_addr_o[9:0]][8*b +: 8] <= d0[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mem1[10'h020] <= 32'h13572468;
            mem1[10'h040] <= 32'h00000000;
        end else if (!bus1.sram_ce_n_o && !bus1.sram_we_n_o) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus1.sram_be_n_o[b]) mem1[bus1.sram_addr_o[9:0]][8*b +: 8] <= d1[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The arbiter must never drive the bus while it has the SRAM outputs enabled.
    always @(negedge clk) begin
        if (!rst) begin
            chk("no_contention0", {31'd0, dut.bus_oe_q & ~bus0.sram_oe_n_o}, 32'd0);
            chk("no_contention1", {31'd0, dut2.bus_oe_q & ~bus1.sram_oe_n_o}, 32'd0);
        end
    end

    function automatic logic ack_of(input int which);
        case (which)
            0:       return bus0.if_ack_o;
            1:       return bus0.mem_ack_o;
            2:       return bus1.if_ack_o;
            default: return bus1.mem_ack_o;
        endcase
    endfunction

    // Called just after inputs are driven; returns the number of edges from the request-sampling
    // edge to the edge that samples the ack high, leaving time at the negedge of the ack cycle.
    task automatic wait_ack(input int which, output int lat);
        lat = -1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_of(which)) begin
                lat = i + 1;
                return;
            end
            @(posedge clk);
        end
    endtask

    int lat;
    int got;
    int exp_order [4];
    logic [4:0] we_n_seq;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus0.if_req_i = 1'b0; bus0.if_addr_i = '0; bus0.mem_req_i = 1'b0; bus0.mem_we_i = 1'b0;
        bus0.mem_be_i = '0; bus0.mem_addr_i = '0; bus0.mem_wdata_i = '0;
        bus1.if_req_i = 1'b0; bus1.if_addr_i = '0; bus1.mem_req_i = 1'b0; bus1.mem_we_i = 1'b0;
        bus1.mem_be_i = '0; bus1.mem_addr_i = '0; bus1.mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ce_n", {31'd0, bus0.sram_ce_n_o}, 32'd1);
        chk("rst_oe_n", {31'd0, bus0.sram_oe_n_o}, 32'd1);
        chk("rst_we_n", {31'd0, bus0.sram_we_n_o}, 32'd1);
        chk("rst_be_n", {28'd0, bus0.sram_be_n_o}, 32'hF);
        chk("rst_addr", {12'd0, bus0.sram_addr_o}, 32'd0);
        chk("rst_acks", {30'd0, bus0.if_ack_o, bus0.mem_ack_o}, 32'd0);
        chk("rst_if_rdata", bus0.if_rdata_o, 32'd0);
        chk("rst_mem_rdata", bus0.mem_rdata_o, 32'd0);
        chk("rst_bus_z", {31'd0, dut.bus_oe_q}, 32'd0);
        rst = 1'b0;

        // 1: IF read of 0x00010
        @(negedge clk);
        bus0.if_req_i = 1'b1; bus0.if_addr_i = 20'h00010;
        #1 chk("t1_stall_req", {31'd0, bus0.stall_if_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_ce_oe_low", {30'd0, bus0.sram_ce_n_o, bus0.sram_oe_n_o}, 32'd0);
        chk("t1_be_n", {28'd0, bus0.sram_be_n_o}, 32'h0);
        chk("t1_addr", {12'd0, bus0.sram_addr_o}, 32'h00010);
        chk("t1_no_ack_yet", {31'd0, bus0.if_ack_o}, 32'd0);
        chk("t1_stall_wait", {31'd0, bus0.stall_if_o}, 32'd1);
        @(negedge clk);
        chk("t1_ack", {31'd0, bus0.if_ack_o}, 32'd1);
        chk("t1_strobes_off", {30'd0, bus0.sram_ce_n_o, bus0.sram_oe_n_o}, 32'd3);
        chk("t1_rdata", bus0.if_rdata_o, 32'h8C220004);
        chk("t1_stall_ack", {31'd0, bus0.stall_if_o}, 32'd0);
        bus0.if_req_i = 1'b0;
        @(negedge clk);
        chk("t1_ack_pulse", {31'd0, bus0.if_ack_o}, 32'd0);
        chk("t1_rdata_held", bus0.if_rdata_o, 32'h8C220004);

        // 2: MEM write 0xDEADBEEF to 0x00100, low half only
        bus0.mem_req_i = 1'b1; bus0.mem_we_i = 1'b1; bus0.mem_be_i = 4'b0011;
        bus0.mem_addr_i = 20'h00100; bus0.mem_wdata_i = 32'hDEADBEEF;
        we_n_seq = 5'b11001;  // bit i = expected we_n i cycles after the request edge
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_we_n", {31'd0, bus0.sram_we_n_o}, {31'd0, we_n_seq[i]});
            chk("t2_ce_n", {31'd0, bus0.sram_ce_n_o}, (i == 4) ? 32'd1 : 32'd0);
            chk("t2_bus_oe", {31'd0, dut.bus_oe_q}, (i == 4) ? 32'd0 : 32'd1);
            chk("t2_ack", {31'd0, bus0.mem_ack_o}, (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                chk("t2_bus_data", d0, 32'hDEADBEEF);
                chk("t2_be_n", {28'd0, bus0.sram_be_n_o}, 32'hC);
            end
        end
        bus0.mem_req_i = 1'b0;
        @(negedge clk);
        chk("t2_ack_pulse", {31'd0, bus0.mem_ack_o}, 32'd0);
        chk("t2_mem", mem0[10'h100], 32'h1234BEEF);

        // 3: both ports request continuously after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
        bus0.mem_we_i = 1'b0; bus0.mem_addr_i = 20'h00200;
        bus0.mem_req_i = 1'b1; bus0.if_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int c = 0; c < 10 && got < 0; c++) begin
                @(negedge clk);
                if (bus0.if_ack_o) got = 0;
                else if (bus0.mem_ack_o) got = 1;
            end
            chk("t3_order", got, exp_order[k]);
            chk("t3_one_ack", {31'd0, bus0.if_ack_o & bus0.mem_ack_o}, 32'd0);
            if (got == 1) chk("t3_mem_rdata", bus0.mem_rdata_o, 32'hCAFEF00D);
            if (got == 0) chk("t3_if_rdata", bus0.if_rdata_o, 32'h8C220004);
            @(negedge clk);
            chk("t3_pulse", {30'd0, bus0.if_ack_o, bus0.mem_ack_o}, 32'd0);
        end
        bus0.mem_req_i = 1'b0; bus0.if_req_i = 1'b0;
        repeat (4) @(negedge clk);

        // 4: MEM write with no byte enables
        bus0.mem_req_i = 1'b1; bus0.mem_we_i = 1'b1; bus0.mem_be_i = 4'b0000;
        bus0.mem_addr_i = 20'h00300; bus0.mem_wdata_i = 32'hFFFFFFFF;
        wait_ack(1, lat);
        chk("t4_latency", lat, 32'd1);
        chk("t4_no_strobe", {30'd0, bus0.sram_ce_n_o, bus0.sram_we_n_o}, 32'd3);
        bus0.mem_req_i = 1'b0;
        @(negedge clk);
        chk("t4_mem", mem0[10'h300], 32'h55AA55AA);

        // 5: reset in the middle of the write pulse
        bus0.mem_req_i = 1'b1; bus0.mem_we_i = 1'b1; bus0.mem_be_i = 4'b1111;
        bus0.mem_addr_i = 20'h00140; bus0.mem_wdata_i = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_pulse", {31'd0, bus0.sram_we_n_o}, 32'd0);
        rst = 1'b1; bus0.mem_req_i = 1'b0;
        @(negedge clk);
        chk("t5_we_n", {31'd0, bus0.sram_we_n_o}, 32'd1);
        chk("t5_ce_n", {31'd0, bus0.sram_ce_n_o}, 32'd1);
        chk("t5_bus_z", {31'd0, dut.bus_oe_q}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_ack", {30'd0, bus0.if_ack_o, bus0.mem_ack_o}, 32'd0);
        end
        bus0.if_req_i = 1'b1; bus0.if_addr_i = 20'h00010;
        wait_ack(0, lat);
        chk("t5_read_latency", lat, 32'd2);
        chk("t5_read_data", bus0.if_rdata_o, 32'h8C220004);
        bus0.if_req_i = 1'b0;
        @(negedge clk);

        // 6: READ_CYCLES=3, WE_CYCLES=1 instance
        bus1.if_req_i = 1'b1; bus1.if_addr_i = 20'h00020;
        wait_ack(2, lat);
        chk("t6_read_latency", lat, 32'd4);
        chk("t6_read_data", bus1.if_rdata_o, 32'h13572468);
        bus1.if_req_i = 1'b0;
        @(negedge clk);
        bus1.mem_req_i = 1'b1; bus1.mem_we_i = 1'b1; bus1.mem_be_i = 4'b1000;
        bus1.mem_addr_i = 20'h00040; bus1.mem_wdata_i = 32'hA5A5A5A5;
        wait_ack(3, lat);
        chk("t6_write_latency", lat, 32'd4);
        bus1.mem_req_i = 1'b0;
        @(negedge clk);
        chk("t6_mem", mem1[10'h040], 32'hA5000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
